pll_reset_sequencer: RTL and testbench

- Drives the active-high `rst` input of a PLL wrapper and consumes its asynchronous `locked` output.
- Sequences PLL reset, waits for lock with timeout and bounded retry, and qualifies lock stability.
- Releases a downstream system reset only once lock is qualified.
- Sits beside the SDRAM/system PLL, clocked from the free-running 50 MHz reference clock.

---
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout
// and bounded retry, qualifies lock stability, then releases system reset.
module pll_reset_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       sw_reset_req,
   input  logic       clr_lock_lost,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       lock_lost,
   output logic       fail,
   output logic [1:0] retry_count,
   output logic [2:0] state
);

   localparam logic [2:0] S_RESET_PLL = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RTY_MAX  = 2'(MAX_RETRIES);

   logic             lk_meta_q;
   logic             lk_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic             lost_q, lost_d;
   logic             lost_set;
   logic             pll_rst_q, pll_rst_d;
   logic             sysn_q, sysn_d;
   logic             fail_q, fail_d;

   // Two-flop synchronizer for the asynchronous lock indicator
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lk_meta_q <= 1'b0;
         lk_q      <= 1'b0;
      end else begin
         lk_meta_q <= pll_locked;
         lk_q      <= lk_meta_q;
      end
   end

   // Next-state, counter, retry and sticky-flag logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      retry_d  = retry_q;
      lost_set = 1'b0;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (lk_q) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = '0;
               retry_d = retry_q + 1'b1;
               state_d = (retry_d == RTY_MAX) ? S_FAIL : S_RESET_PLL;
            end
         end
         S_STABLE: begin
            if (!lk_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lk_q) begin
               state_d  = S_RESET_PLL;
               retry_d  = 2'd0;
               lost_set = 1'b1;
            end
         end
         S_FAIL: begin
            cnt_d = '0;
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
         end
      endcase
      if (sw_reset_req) begin
         state_d  = S_RESET_PLL;
         cnt_d    = '0;
         retry_d  = 2'd0;
         lost_set = 1'b0;
      end
      lost_d    = lost_set | (lost_q & ~clr_lock_lost);
      pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sysn_d    = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
   end

   // Registered state and outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= 2'd0;
         lost_q    <= 1'b0;
         pll_rst_q <= 1'b1;
         sysn_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         lost_q    <= lost_d;
         pll_rst_q <= pll_rst_d;
         sysn_q    <= sysn_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_reset_n = sysn_q;
   assign lock_lost   = lost_q;
   assign fail        = fail_q;
   assign retry_count = retry_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: cycle table for the main
// lock / retry / fail flow, plus hand sequences for multi-cycle corners.
module tb_pll_reset_sequencer;

   logic       clk;
   logic       reset_n;
   logic       pll_locked;
   logic       sw_reset_req;
   logic       clr_lock_lost;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       lock_lost;
   logic       fail;
   logic [1:0] retry_count;
   logic [2:0] state;

   int ncmp  = 0;
   int nfail = 0;

   typedef struct {
      logic       lk;
      logic       sw;
      logic       clr;
      logic       prst;
      logic       sysn;
      logic       ll;
      logic       fl;
      logic [1:0] rc;
      logic [2:0] st;
   } vec_t;

   vec_t vq[$];

   pll_reset_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (3),
      .CNT_W        (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .clr_lock_lost(clr_lock_lost),
      .pll_rst      (pll_rst),
      .sys_reset_n  (sys_reset_n),
      .lock_lost    (lock_lost),
      .fail         (fail),
      .retry_count  (retry_count),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void addn(input int n, input logic lk, input logic sw,
                                input logic clr, input logic prst,
                                input logic sysn, input logic ll,
                                input logic fl, input logic [1:0] rc,
                                input logic [2:0] st);
      vec_t v;
      v.lk = lk; v.sw = sw; v.clr = clr;
      v.prst = prst; v.sysn = sysn; v.ll = ll;
      v.fl = fl; v.rc = rc; v.st = st;
      for (int k = 0; k < n; k++) vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // apply inputs now, then sample just after the next rising edge
   task automatic cyc(input logic lk, input logic sw, input logic clr);
      pll_locked    = lk;
      sw_reset_req  = sw;
      clr_lock_lost = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      pll_locked    = 1'b0;
      sw_reset_req  = 1'b0;
      clr_lock_lost = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] exp, input logic lk,
                             input int bound, input string nm);
      int n = 0;
      while (state !== exp && n < bound) begin
         cyc(lk, 1'b0, 1'b0);
         n++;
      end
      ncmp++;
      if (state !== exp) begin
         nfail++;
         $display("FAIL %s: state=%0d expected %0d after %0d cycles",
                  nm, state, exp, n);
      end
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, ".state"}, 32'(state), 32'd0);
      chk({p, ".pll_rst"}, 32'(pll_rst), 32'd1);
      chk({p, ".sys_reset_n"}, 32'(sys_reset_n), 32'd0);
      chk({p, ".lock_lost"}, 32'(lock_lost), 32'd0);
      chk({p, ".fail"}, 32'(fail), 32'd0);
      chk({p, ".retry_count"}, 32'(retry_count), 32'd0);
   endtask

   initial begin
      // main flow: lock after 10 cycles, then sw reset, then 3 timeouts
      addn(3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      addn(7, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      addn(2, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      addn(8, 1, 0, 0, 0, 0, 0, 0, 0, 2);
      addn(5, 1, 0, 0, 0, 1, 0, 0, 0, 3);
      addn(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      addn(3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      addn(20, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      addn(4, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      addn(20, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      addn(4, 0, 0, 0, 1, 0, 0, 0, 2, 0);
      addn(20, 0, 0, 0, 0, 0, 0, 0, 2, 1);
      addn(3, 0, 0, 0, 1, 0, 0, 1, 3, 4);
      addn(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      addn(2, 0, 0, 0, 1, 0, 0, 0, 0, 0);

      reset_n       = 1'b0;
      pll_locked    = 1'b0;
      sw_reset_req  = 1'b0;
      clr_lock_lost = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vq[i]) begin
         cyc(vq[i].lk, vq[i].sw, vq[i].clr);
         chk($sformatf("v%0d.state", i), 32'(state), 32'(vq[i].st));
         chk($sformatf("v%0d.pll_rst", i), 32'(pll_rst), 32'(vq[i].prst));
         chk($sformatf("v%0d.sys_reset_n", i), 32'(sys_reset_n),
             32'(vq[i].sysn));
         chk($sformatf("v%0d.lock_lost", i), 32'(lock_lost), 32'(vq[i].ll));
         chk($sformatf("v%0d.fail", i), 32'(fail), 32'(vq[i].fl));
         chk($sformatf("v%0d.retry", i), 32'(retry_count), 32'(vq[i].rc));
      end

      // STABLE glitch with a nonzero retry count
      do_reset();
      repeat (24) cyc(1'b0, 1'b0, 1'b0);
      chk("pre.state", 32'(state), 32'd0);
      chk("pre.retry", 32'(retry_count), 32'd1);
      wait_state(3'd2, 1'b1, 20, "to_stable");
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("glitch.cnt5.state", 32'(state), 32'd2);
      cyc(1'b1, 1'b0, 1'b0);
      chk("glitch.drop.state", 32'(state), 32'd1);
      chk("glitch.drop.retry", 32'(retry_count), 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("glitch.reenter.state", 32'(state), 32'd2);
      repeat (7) cyc(1'b1, 1'b0, 1'b0);
      chk("fresh7.state", 32'(state), 32'd2);
      chk("fresh7.sys_reset_n", 32'(sys_reset_n), 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("fresh8.state", 32'(state), 32'd3);
      chk("fresh8.sys_reset_n", 32'(sys_reset_n), 32'd1);
      chk("fresh8.retry", 32'(retry_count), 32'd1);

      // lock drop in RUN, clear coinciding with the set
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("drop1.state", 32'(state), 32'd3);
      chk("drop1.sys_reset_n", 32'(sys_reset_n), 32'd1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("drop2.state", 32'(state), 32'd0);
      chk("drop2.sys_reset_n", 32'(sys_reset_n), 32'd0);
      chk("drop2.lock_lost", 32'(lock_lost), 32'd1);
      chk("drop2.retry", 32'(retry_count), 32'd0);
      chk("drop2.pll_rst", 32'(pll_rst), 32'd1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("pulse4.pll_rst", 32'(pll_rst), 32'd1);
      chk("pulse4.lock_lost", 32'(lock_lost), 32'd1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("pulse_end.pll_rst", 32'(pll_rst), 32'd0);
      chk("pulse_end.state", 32'(state), 32'd1);

      // sw reset from RUN keeps lock_lost; later clear drops it
      wait_state(3'd3, 1'b1, 40, "to_run");
      chk("run2.lock_lost", 32'(lock_lost), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("swrun.state", 32'(state), 32'd0);
      chk("swrun.sys_reset_n", 32'(sys_reset_n), 32'd0);
      chk("swrun.lock_lost", 32'(lock_lost), 32'd1);
      chk("swrun.pll_rst", 32'(pll_rst), 32'd1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("clr.lock_lost", 32'(lock_lost), 32'd0);

      // asynchronous reset mid-STABLE, between clock edges
      do_reset();
      wait_state(3'd2, 1'b1, 20, "to_stable2");
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      chk("mid.state", 32'(state), 32'd2);
      chk("mid.pll_rst", 32'(pll_rst), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
